// File: rtl/spi_reg_sequencer.sv
// Two-port register command sequencer in front of spi_main: round-robin arbitration,
// single-cycle SPI launch, completion/timeout handling, and a forced inter-transfer gap.
module spi_reg_sequencer #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_mode,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_err,
    input  logic                  b_req,
    input  logic                  b_mode,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_err,
    output logic                  spi_en,
    output logic                  spi_mode,
    output logic [ADDR_WIDTH-1:0] spi_addr,
    output logic [DATA_WIDTH-1:0] spi_wdata,
    output logic                  spi_wvalid,
    input  logic [DATA_WIDTH-1:0] spi_rdata,
    input  logic                  spi_done,
    output logic                  busy,
    output logic [2:0]            state_dbg
);

    // Handshake: a requester raises req with stable mode/addr/wdata and holds them until
    // its one-cycle ack; ack completes the command and qualifies err (and rdata on reads).

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARB    = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4,
        S_GAP    = 3'd5
    } state_t;

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GW = $clog2(GAP_CYCLES) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GAP_CYCLES - 1);

    state_t          state;
    logic            grant_b;
    logic            last_b;
    logic            done_q;
    logic [TW-1:0]   tcnt;
    logic [GW-1:0]   gcnt;
    logic            done_rise;
    logic            pick_b;

    assign done_rise = spi_done & ~done_q;
    // B wins when it is the only requester, or on a tie when A was granted last.
    assign pick_b    = b_req & (~a_req | ~last_b);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant_b    <= 1'b0;
            last_b     <= 1'b1;
            done_q     <= 1'b0;
            tcnt       <= '0;
            gcnt       <= '0;
            a_ack      <= 1'b0;
            a_err      <= 1'b0;
            a_rdata    <= '0;
            b_ack      <= 1'b0;
            b_err      <= 1'b0;
            b_rdata    <= '0;
            spi_en     <= 1'b0;
            spi_mode   <= 1'b0;
            spi_addr   <= '0;
            spi_wdata  <= '0;
            spi_wvalid <= 1'b0;
        end else begin
            done_q <= spi_done;
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
            a_err  <= 1'b0;
            b_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (a_req | b_req) state <= S_ARB;
                end
                S_ARB: begin
                    grant_b    <= pick_b;
                    last_b     <= pick_b;
                    spi_mode   <= pick_b ? b_mode  : a_mode;
                    spi_addr   <= pick_b ? b_addr  : a_addr;
                    spi_wdata  <= pick_b ? b_wdata : a_wdata;
                    spi_wvalid <= pick_b ? b_mode  : a_mode;
                    spi_en     <= 1'b1;
                    state      <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    spi_en <= 1'b0;
                    tcnt   <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (done_rise) begin
                        if (!spi_mode) begin
                            if (grant_b) b_rdata <= spi_rdata;
                            else         a_rdata <= spi_rdata;
                        end
                        a_ack      <= ~grant_b;
                        b_ack      <= grant_b;
                        spi_wvalid <= 1'b0;
                        state      <= S_RESP;
                    end else if (tcnt == T_LAST) begin
                        a_ack      <= ~grant_b;
                        b_ack      <= grant_b;
                        a_err      <= ~grant_b;
                        b_err      <= grant_b;
                        spi_wvalid <= 1'b0;
                        state      <= S_RESP;
                    end else if (tcnt != '1) begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                S_RESP: begin
                    gcnt  <= '0;
                    state <= S_GAP;
                end
                S_GAP: begin
                    if (gcnt == G_LAST) state <= S_IDLE;
                    else if (gcnt != '1) gcnt <= gcnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Directed + randomized bench for spi_reg_sequencer; the SPI main is modelled as a
// register array answering after a chosen delay, grants follow a round-robin model.
module tb_spi_reg_sequencer;

    localparam int AW = 6;
    localparam int DW = 8;
    localparam int G  = 4;
    localparam int T  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req_f   [2];
    logic          mode_f  [2];
    logic [AW-1:0] addr_f  [2];
    logic [DW-1:0] wdata_f [2];
    logic          spi_done;
    logic [DW-1:0] spi_rdata;

    logic          a_ack, a_err, b_ack, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          spi_en, spi_mode, spi_wvalid, busy;
    logic [AW-1:0] spi_addr;
    logic [DW-1:0] spi_wdata;
    logic [2:0]    state_dbg;

    spi_reg_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .a_req(req_f[0]), .a_mode(mode_f[0]), .a_addr(addr_f[0]), .a_wdata(wdata_f[0]),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(req_f[1]), .b_mode(mode_f[1]), .b_addr(addr_f[1]), .b_wdata(wdata_f[1]),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .spi_en(spi_en), .spi_mode(spi_mode), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_wvalid(spi_wvalid), .spi_rdata(spi_rdata), .spi_done(spi_done),
        .busy(busy), .state_dbg(state_dbg)
    );

    int            n_assert = 0;
    int            n_fail   = 0;
    int            t_cycle  = 0;
    int            t_en     = 0;
    int            last_done_t = 0;
    int            last_grant  = 1;
    logic [DW-1:0] mem    [64];
    logic [DW-1:0] exp_rd [2];

    task automatic tick();
        @(negedge clk);
        t_cycle++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 1) ? b_ack : a_ack;
    endfunction

    function automatic logic err_of(input int p);
        return (p == 1) ? b_err : a_err;
    endfunction

    function automatic logic [DW-1:0] rd_of(input int p);
        return (p == 1) ? b_rdata : a_rdata;
    endfunction

    function automatic int pick();
        if (req_f[0] && req_f[1]) return 1 - last_grant;
        return req_f[0] ? 0 : 1;
    endfunction

    task automatic new_cmd(input int p, input logic mode);
        req_f[p]   = 1'b1;
        mode_f[p]  = mode;
        addr_f[p]  = AW'($urandom_range(0, 63));
        wdata_f[p] = DW'($urandom);
    endtask

    task automatic model_reset();
        last_grant = 1;
        exp_rd[0]  = '0;
        exp_rd[1]  = '0;
    endtask

    task automatic wait_en(output bit ok);
        int w = 0;
        tick();
        while (spi_en !== 1'b1 && w < 300) begin
            tick();
            w++;
        end
        t_en = t_cycle;
        ok = (spi_en === 1'b1);
        check("spi_en_seen", 32'(spi_en), 1);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy !== 1'b0 && w < 200) begin
            tick();
            w++;
        end
        check("return_idle", 32'(busy), 0);
    endtask

    // Expects port p to be granted, answers after 'delay' cycles, checks the ack.
    task automatic serve(input int p, input int delay, input bit chk_gap);
        bit   ok;
        logic stray = 1'b0;
        wait_en(ok);
        if (!ok) return;
        if (chk_gap) check("done_to_en_gap", 32'(t_en - last_done_t), G + 4);
        check("spi_mode", 32'(spi_mode), 32'(mode_f[p]));
        check("spi_addr", 32'(spi_addr), 32'(addr_f[p]));
        check("spi_wdata", 32'(spi_wdata), 32'(wdata_f[p]));
        check("spi_wvalid_launch", 32'(spi_wvalid), 32'(mode_f[p]));
        for (int i = 1; i < delay; i++) begin
            tick();
            if (i == 1) begin
                check("spi_en_pulse", 32'(spi_en), 0);
                check("spi_wvalid_hold", 32'(spi_wvalid), 32'(mode_f[p]));
            end
            stray |= a_ack | b_ack;
        end
        check("no_early_ack", 32'(stray), 0);
        spi_rdata = mode_f[p] ? DW'($urandom) : mem[addr_f[p]];
        spi_done  = 1'b1;
        last_done_t = t_cycle;
        tick();
        check("ack_granted", 32'(ack_of(p)), 1);
        check("ack_other", 32'(ack_of(1 - p)), 0);
        check("err_clear", 32'(err_of(p)), 0);
        if (mode_f[p]) mem[addr_f[p]] = wdata_f[p];
        else           exp_rd[p] = mem[addr_f[p]];
        check("rdata", 32'(rd_of(p)), 32'(exp_rd[p]));
        spi_done   = 1'b0;
        last_grant = p;
    endtask

    initial begin
        bit   ok;
        int   p, cnt, t_req;
        logic stray;

        for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 2; i++) begin
            req_f[i] = 1'b0; mode_f[i] = 1'b0; addr_f[i] = '0; wdata_f[i] = '0;
        end
        spi_done = 1'b0;
        spi_rdata = '0;
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        check("rst_outputs", {a_ack, a_err, b_ack, b_err, spi_en, spi_mode, spi_wvalid, busy}, 0);
        check("rst_spi_fields", {spi_addr, spi_wdata}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        rst = 1'b0;
        tick();

        // Single A write, SPI completes 20 cycles after launch.
        req_f[0] = 1'b1; mode_f[0] = 1'b1; addr_f[0] = 6'h2A; wdata_f[0] = 8'hC3;
        t_req = t_cycle;
        serve(pick(), 20, 1'b0);
        check("req_to_en_latency", 32'(t_en - t_req), 2);
        req_f[0] = 1'b0;
        tick();
        check("ack_one_cycle", 32'(a_ack | b_ack), 0);
        wait_idle();

        // Single B read of address 0x05 returning 0x5A.
        mem[5] = 8'h5A;
        req_f[1] = 1'b1; mode_f[1] = 1'b0; addr_f[1] = 6'h05; wdata_f[1] = 8'h00;
        serve(pick(), $urandom_range(2, 30), 1'b0);
        req_f[1] = 1'b0;
        check("b_rdata_5a", 32'(b_rdata), 32'h5A);
        for (int i = 0; i < 3; i++) tick();
        check("b_rdata_held", 32'(b_rdata), 32'h5A);
        wait_idle();

        // Both ports requesting continuously from reset: grants must alternate.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        new_cmd(0, 1'($urandom));
        new_cmd(1, 1'($urandom));
        addr_f[1] = addr_f[0] ^ 6'h01;
        for (int i = 0; i < 4; i++) begin
            p = pick();
            serve(p, $urandom_range(2, 25), i > 0);
            new_cmd(p, 1'($urandom));
            addr_f[p] = addr_f[1 - p] ^ 6'h01;
        end
        req_f[0] = 1'b0;
        req_f[1] = 1'b0;
        wait_idle();

        // Randomized single-port traffic checked against the register model.
        for (int i = 0; i < 6; i++) begin
            p = int'($urandom_range(0, 1));
            new_cmd(p, 1'($urandom));
            if (i > 0 && ($urandom_range(0, 1) == 1)) addr_f[p] = addr_f[1 - p];
            serve(pick(), $urandom_range(2, 30), 1'b0);
            req_f[p] = 1'b0;
            wait_idle();
        end

        // Timeout: SPI never completes.
        new_cmd(0, 1'b0);
        wait_en(ok);
        cnt = 0;
        while (a_ack !== 1'b1 && cnt < T + 20) begin
            tick();
            cnt++;
        end
        check("timeout_latency", 32'(cnt), T + 1);
        check("timeout_err", 32'(a_err), 1);
        check("timeout_rdata_held", 32'(a_rdata), 32'(exp_rd[0]));
        check("timeout_b_ack", 32'(b_ack), 0);
        req_f[0] = 1'b0;
        last_grant = 0;
        tick();
        check("err_with_ack_only", 32'(a_err), 0);
        wait_idle();
        new_cmd(1, 1'b1);
        serve(pick(), $urandom_range(2, 30), 1'b0);
        req_f[1] = 1'b0;
        wait_idle();

        // Reset pulsed mid-transfer; the held request must be re-arbitrated.
        new_cmd(1, 1'b1);
        wait_en(ok);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_outputs", {spi_en, spi_wvalid, busy, a_ack, b_ack, a_err, b_err}, 0);
        rst = 1'b0;
        model_reset();
        stray = 1'b0;
        serve(pick(), $urandom_range(2, 30), 1'b0);
        req_f[1] = 1'b0;
        wait_idle();

        // spi_done already high at launch must not count as completion.
        spi_done = 1'b1;
        new_cmd(0, 1'b0);
        wait_en(ok);
        for (int i = 0; i < 6; i++) begin
            tick();
            stray |= a_ack | b_ack;
        end
        check("stale_done_ignored", 32'(stray), 0);
        check("stale_done_busy", 32'(busy), 1);
        spi_done = 1'b0;
        tick();
        tick();
        spi_rdata = mem[addr_f[0]];
        spi_done  = 1'b1;
        tick();
        check("fresh_done_ack", 32'(a_ack), 1);
        check("fresh_done_rdata", 32'(a_rdata), 32'(mem[addr_f[0]]));
        spi_done = 1'b0;
        req_f[0] = 1'b0;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_sequencer.md
Name: spi_reg_sequencer

Overview:
- Command sequencer in front of the SPI main: accepts register read/write commands from two requesters (host port A, housekeeping port B), arbitrates between them, and drives the SPI main's en/mode/rw_addr/write_data/write_valid inputs.
- Captures read data from the SPI main and returns it to the granted requester.
- Enforces an inter-transaction cooldown gap between consecutive SPI transfers.
- Sits between the system bus glue and spi_main.

Parameters:
- ADDR_WIDTH, 6, register address width; must match spi_main.
- DATA_WIDTH, 8, register data width; must match spi_main.
- GAP_CYCLES, 4, idle clk cycles forced between end of one SPI transfer and start of the next (minimum 1).
- TIMEOUT_CYCLES, 64, max clk cycles waiting for spi_done before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- a_req  in  1  port A command valid.
- a_mode  in  1  port A direction: 1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  port A register address.
- a_wdata  in  DATA_WIDTH  port A write data.
- a_ack  out  1  one-cycle pulse: port A command complete.
- a_rdata  out  DATA_WIDTH  port A read data; valid with a_ack on reads.
- a_err  out  1  qualifies a_ack: transaction timed out.
- b_req, b_mode, b_addr, b_wdata, b_ack, b_rdata, b_err  same meanings, port B.
- spi_en  out  1  enable to SPI main.
- spi_mode  out  1  direction to SPI main.
- spi_addr  out  ADDR_WIDTH  address to SPI main.
- spi_wdata  out  DATA_WIDTH  write data to SPI main.
- spi_wvalid  out  1  write data valid to SPI main.
- spi_rdata  in  DATA_WIDTH  read data from SPI main.
- spi_done  in  1  SPI main read_valid/transfer-complete indicator; rising edge marks completion.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; all outputs 0; rdata registers 0; last_grant=B, so A wins first tie; gap counter 0; spi_done edge register 0.
- Requests are level: a requester holds req and its fields stable until its ack. Deasserting req before ack is illegal and is not checked.
- States: IDLE, ARB, LAUNCH, WAIT, RESP, GAP.
- IDLE: go to ARB when a_req|b_req.
- ARB (1 cycle): round-robin grant.
  - Only one requesting: grant it.
  - Both requesting: grant the port not in last_grant.
  - Latch the granted mode/addr/wdata into spi_* outputs; update last_grant; go to LAUNCH.
- LAUNCH: spi_en=1; spi_wvalid=spi_mode; clear timeout counter; go to WAIT next cycle.
- WAIT:
  - spi_en stays 1 until the first cycle after LAUNCH, then drops to 0 so spi_main does not restart.
  - spi_wvalid is held through WAIT.
  - On spi_done rising edge (registered previous-value compare): capture spi_rdata into the granted port's rdata if read; go to RESP.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without spi_done: set err flag; go to RESP.
- RESP (1 cycle): pulse the granted port's ack; err output = err flag, valid only while ack=1. rdata is held until that port's next ack. Go to GAP.
- GAP: count GAP_CYCLES cycles with spi_en=0 and spi_wvalid=0, then go to IDLE.
- Minimum request-to-ack latency: ARB + LAUNCH + spi transfer + 1. Back-to-back requests are spaced by at least GAP_CYCLES+1 idle cycles between spi_done and the next spi_en.
- A request arriving during any non-IDLE state waits. No request is dropped, and no port is starved: with both always requesting, grants alternate strictly.
- spi_done already high on entry to WAIT does not count; only a 0->1 transition counts.
- rst asserted mid-transfer: return to IDLE next cycle, spi_en=0, no ack issued; the requester must reissue.
- Counter widths: $clog2(param)+1; counters saturate and do not wrap.

Test Plan:
- Single A write (addr 0x2A, data 0xC3): spi_mode=1, spi_addr=0x2A, spi_wdata=0xC3, spi_en pulses 1 cycle; spi_done after 20 cycles -> a_ack 1 cycle later, a_err=0, b_ack never.
- Single B read (addr 0x05), spi_rdata=0x5A at spi_done -> b_ack with b_rdata=0x5A; value held after ack.
- a_req and b_req both held for 4 transactions from reset -> grant order A,B,A,B; each spi_en separated from the previous spi_done by ≥GAP_CYCLES+1 cycles.
- spi_done never asserts -> a_ack with a_err=1 exactly TIMEOUT_CYCLES+1 cycles after LAUNCH; the next request proceeds normally.
- rst pulsed during WAIT -> outputs 0 next cycle, no ack; the held request is re-arbitrated and completes.
- spi_done held high from before LAUNCH -> no completion until it falls and rises again.
